// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 initiator: FSM state encoding,
// clock mode constants and a sizing helper for the half-period counter.
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_HIGH  = 3'd2;
    localparam spi_state_t ST_LOW   = 3'd3;
    localparam spi_state_t ST_HOLD  = 3'd4;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Bits needed to count 0..div-1, never less than one bit.
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Half-period timer: counts clkDiv cycles and flags the last one.
// Held at zero while restart is high so each state starts a fresh count.
module spi_halfperiod_timer
    import spi_pkg::*;
#(
    parameter int clkDiv = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic expire
);

    localparam int CW = cnt_width(clkDiv);
    localparam logic [CW-1:0] LAST = CW'(clkDiv - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on restart or at the end of a half-period, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = !restart && (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, one full-duplex word per transaction.
// States SETUP/HIGH/LOW/HOLD each last clkDiv cycles; all outputs registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int width  = 8,
    parameter int clkDiv = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] txData,
    output logic [width-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(width);
    localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

    spi_state_t       state_q, state_d;
    // The MSB goes straight to mosi at acceptance, so only the rest is kept.
    logic [width-2:0] tx_q, tx_d;
    logic [width-1:0] rx_q, rx_d;
    logic [width-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             expire_s;

    spi_halfperiod_timer #(.clkDiv(clkDiv)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == ST_IDLE),
        .expire  (expire_s)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next-state logic: advance at the end of each half-period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SETUP; else state_d = ST_IDLE;
            ST_SETUP: if (expire_s) state_d = ST_HIGH;  else state_d = ST_SETUP;
            ST_HIGH: begin
                if (expire_s) begin
                    if (bit_cnt_q == LAST_BIT) state_d = ST_HOLD;
                    else                       state_d = ST_LOW;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW:   if (expire_s) state_d = ST_HIGH;  else state_d = ST_LOW;
            ST_HOLD:  if (expire_s) state_d = ST_IDLE;  else state_d = ST_HOLD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and shifter updates; everything holds except done, which pulses.
    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d      = txData[width-2:0];
                    cs_n_d    = 1'b0;
                    mosi_d    = txData[width-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    busy_d = busy_q;
                end
            end
            ST_SETUP, ST_LOW: begin
                // Rising sclk edge: miso is captured on this same clk edge.
                if (expire_s) begin
                    sclk_d = ~CPOL;
                    rx_d   = {rx_q[width-2:0], miso};
                end else begin
                    sclk_d = sclk_q;
                end
            end
            ST_HIGH: begin
                // Falling sclk edge: present the next bit unless the word is done.
                if (expire_s) begin
                    sclk_d = CPOL;
                    if (bit_cnt_q != LAST_BIT) begin
                        mosi_d    = tx_q[width-2];
                        tx_d      = tx_q << 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end else begin
                        mosi_d = mosi_q;
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            ST_HOLD: begin
                if (expire_s) begin
                    cs_n_d    = 1'b1;
                    sclk_d    = CPOL;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                end else begin
                    cs_n_d = cs_n_q;
                end
            end
            default: begin
                cs_n_d = 1'b1;
                sclk_d = CPOL;
                mosi_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign rxData = rx_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign cs_n   = cs_n_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a default instance (8 bits, clkDiv 4) driven by a
// slave model, and a 16-bit clkDiv=1 instance with miso looped back from mosi.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Default instance signals
    logic       start0;
    logic [7:0] tx0;
    logic [7:0] rx0;
    logic       busy0, done0, sclk0, cs0, mosi0;
    logic       miso0 = 1'b0;

    // Fast instance signals
    logic        start1;
    logic [15:0] tx1;
    logic [15:0] rx1;
    logic        busy1, done1, sclk1, cs1, mosi1;
    logic        miso1;
    assign miso1 = mosi1;

    spi_master #(.width(8), .clkDiv(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .txData(tx0), .rxData(rx0),
        .busy(busy0), .done(done0), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .miso(miso0)
    );

    spi_master #(.width(16), .clkDiv(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .txData(tx1), .rxData(rx1),
        .busy(busy1), .done(done1), .sclk(sclk1), .cs_n(cs1), .mosi(mosi1), .miso(miso1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model and bus monitor for the default instance.
    logic [7:0] slave_word0 = 8'h00;
    int         sidx0 = 0;
    logic       psclk0 = 1'b0, pcs0 = 1'b1;
    logic [7:0] cap0 = 8'h00;
    int         rises0 = 0;
    int         dones0 = 0;
    always @(negedge clk) begin
        if (cs0 === 1'b1) begin
            sidx0 = 0;
            miso0 = slave_word0[7];
        end else if (sclk0 === 1'b0 && psclk0 === 1'b1) begin
            sidx0++;
            if (sidx0 < 8) miso0 = slave_word0[7 - sidx0];
        end
        if (cs0 === 1'b0 && pcs0 === 1'b1) begin
            cap0   = 8'h00;
            rises0 = 0;
        end
        if (sclk0 === 1'b1 && psclk0 === 1'b0) begin
            cap0 = {cap0[6:0], mosi0};
            rises0++;
        end
        if (done0 === 1'b1) dones0++;
        psclk0 = sclk0;
        pcs0   = cs0;
    end

    // Bus monitor for the fast instance, including a toggle-every-cycle check.
    logic        psclk1 = 1'b0, pcs1 = 1'b1;
    logic [15:0] cap1 = 16'h0000;
    int          rises1 = 0;
    int          notog1 = 0;
    always @(negedge clk) begin
        if (cs1 === 1'b0 && pcs1 === 1'b1) begin
            cap1   = 16'h0000;
            rises1 = 0;
        end
        if (cs1 === 1'b0 && pcs1 === 1'b0 && sclk1 === psclk1) notog1++;
        if (sclk1 === 1'b1 && psclk1 === 1'b0) begin
            cap1 = {cap1[14:0], mosi1};
            rises1++;
        end
        psclk1 = sclk1;
        pcs1   = cs1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (from a negedge) for done0, bounded; returns 1 if seen.
    task automatic wait_done0(input int bound, output bit got);
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            if (done0 === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    // One transfer on the default instance; optionally pokes start/txData mid-word.
    task automatic xfer0(input logic [7:0] tx, input logic [7:0] sw, input bit disturb, input string tag);
        int t0;
        int d0;
        bit got;
        @(negedge clk);
        slave_word0 = sw;
        tx0 = tx;
        start0 = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start0 = 1'b0;
        d0 = dones0;
        check({tag, "_cs_low"}, 32'(cs0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd1);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (disturb && k == 20) begin start0 = 1'b1; tx0 = ~tx; end
            if (disturb && k == 22) start0 = 1'b0;
            if (done0 === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc - t0), 32'd68);
        check({tag, "_rx"}, 32'(rx0), 32'(sw));
        check({tag, "_mosi_bits"}, 32'(cap0), 32'(tx));
        check({tag, "_rises"}, 32'(rises0), 32'd8);
        check({tag, "_end_bus"}, {29'd0, cs0, sclk0, mosi0}, 32'd4);
        check({tag, "_end_busy"}, 32'(busy0), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done0), 32'd0);
        if (disturb) begin
            repeat (80) @(negedge clk);
            check({tag, "_single_done"}, 32'(dones0 - d0), 32'd1);
            check({tag, "_no_requeue"}, 32'(cs0), 32'd1);
        end
    endtask

    // One loopback transfer on the fast instance.
    task automatic xfer1(input logic [15:0] tx, input string tag);
        int t0;
        bit got;
        @(negedge clk);
        tx1 = tx;
        start1 = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (done1 === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc - t0), 32'd33);
        check({tag, "_rx"}, 32'(rx1), 32'(tx));
        check({tag, "_mosi_bits"}, 32'(cap1), 32'(tx));
        check({tag, "_rises"}, 32'(rises1), 32'd16);
        check({tag, "_end_cs"}, 32'(cs1), 32'd1);
    endtask

    initial begin
        int idle_bad;
        int t1;
        int t2;
        int d0;
        bit got;
        logic [7:0] w;
        logic [7:0] s;

        rst_n = 1'b0;
        start0 = 1'b0; tx0 = 8'h00;
        start1 = 1'b0; tx1 = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and 20 idle cycles
        check("rst_cs_n", 32'(cs0), 32'd1);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_mosi", 32'(mosi0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_rx", 32'(rx0), 32'd0);
        check("rst_bus1", {25'd0, cs1, sclk1, mosi1, busy1, done1, 2'b00}, 32'd64);
        check("rst_rx1", 32'(rx1), 32'd0);
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cs0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || busy0 !== 1'b0 ||
                done0 !== 1'b0 || rx0 !== 8'h00) idle_bad++;
        end
        check("idle_outputs", 32'(idle_bad), 32'd0);

        // Directed A5 / 3C transfer
        xfer0(8'hA5, 8'h3C, 1'b0, "a5");

        // Randomized words against the slave model
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            s = 8'($urandom);
            xfer0(w, s, 1'b0, "rand");
        end

        // Back-to-back: start held high for FF then 00
        @(negedge clk);
        slave_word0 = 8'h5A;
        tx0 = 8'hFF;
        start0 = 1'b1;
        @(posedge clk);
        #1 t1 = cyc;
        @(negedge clk);
        tx0 = 8'h00;
        wait_done0(200, got);
        check("b2b_done1_seen", 32'(got), 32'd1);
        check("b2b_lat1", 32'(cyc - t1), 32'd68);
        t1 = cyc;
        check("b2b_word1_bits", 32'(cap0), 32'hFF);
        check("b2b_rx1", 32'(rx0), 32'h5A);
        check("b2b_cs_high", 32'(cs0), 32'd1);
        @(negedge clk);
        start0 = 1'b0;
        check("b2b_cs_relow", 32'(cs0), 32'd0);
        wait_done0(200, got);
        check("b2b_done2_seen", 32'(got), 32'd1);
        t2 = cyc;
        check("b2b_done_gap", 32'(t2 - t1), 32'd69);
        check("b2b_word2_bits", 32'(cap0), 32'h00);
        check("b2b_rx2", 32'(rx0), 32'h5A);
        repeat (3) @(negedge clk);
        check("b2b_idle_cs", 32'(cs0), 32'd1);

        // Reset during bit 4
        @(negedge clk);
        slave_word0 = 8'hC3;
        tx0 = 8'h96;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (rises0 >= 5) got = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_reached", 32'(got), 32'd1);
        d0 = dones0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_bus", {29'd0, cs0, sclk0, mosi0}, 32'd4);
        check("rst_mid_busy", 32'(busy0), 32'd0);
        check("rst_mid_rx", 32'(rx0), 32'd0);
        repeat (100) @(negedge clk);
        check("rst_mid_no_done", 32'(dones0 - d0), 32'd0);
        xfer0(8'h69, 8'hE1, 1'b0, "post_rst");

        // start pulsed while busy, txData changed mid-transfer
        xfer0(8'hB4, 8'h27, 1'b1, "busy_start");

        // clkDiv=1, width=16 loopback
        xfer1(16'h8001, "fast8001");
        for (int i = 0; i < 3; i++) begin
            xfer1(16'($urandom), "fast_rand");
        end
        check("fast_sclk_toggle", 32'(notog1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
